mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters: the K&S core (port C, fetch and load/store) and the program loader/debug port (port L).
- Sits between control_unit/datapath address logic and the RAM macro.
- Owns the RAM control pins and returns read data with a fixed one-cycle latency.
- Supports round-robin arbitration, with fixed-priority as a compile-time option.

Parameters:
- ADDR_W, 5, RAM word-address width.
- DATA_W, 16, RAM word width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- c_req  in  1  core access request; held with c_we/c_addr/c_wdata stable until c_gnt
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core access issued to RAM this cycle
- c_rvalid  out  1  c_rdata valid (cycle after a core read grant)
- c_rdata  out  DATA_W  core read data
- l_req, l_we, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata  same as the c_* ports, for the loader
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write strobe
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after address
- busy  out  1  a grant is active this cycle

Behaviour:
- FSM states (mem_arb_state_t): ARB_IDLE, ARB_CORE, ARB_LOAD. Registered state; arbitration decision is combinational from the req lines.
- Reset (async): state=ARB_IDLE, last-served pointer=LOAD (core wins the first tie), c_rvalid=l_rvalid=0. All gnt, ram_we, and busy are 0; ram_addr, ram_wdata, c_rdata, and l_rdata are 0.
- ARB_IDLE: no grant, ram_we=0, ram_addr=0.
- ARB_CORE:
  - c_gnt=1, busy=1.
  - ram_addr=c_addr, ram_wdata=c_wdata, ram_we=c_we.
  - ram_we is never asserted outside a grant state.
- ARB_LOAD: mirror of ARB_CORE using the l_* ports.
- Grant latency: req sampled high at edge N moves state to the grant state; gnt is high during cycle N+1.
- Next-state rule, evaluated every cycle:
  - The requester granted this cycle has its req masked for this decision. A lone continuous requester is therefore served every second cycle.
  - Alternating requesters can be served back-to-back.
  - Only one unmasked req high: grant it.
  - Both high: grant the one not last served (round-robin); update the pointer on each grant.
  - None high: ARB_IDLE.
- Read return:
  - c_rvalid=1 exactly one cycle after a c_gnt with c_we=0. c_rdata is registered from ram_rdata that cycle and holds its value until the next core read.
  - Same rule for the L port.
  - Writes produce no rvalid.
- A req dropped before its gnt is legal: it is withdrawn, and no access occurs.
- Reset mid-grant aborts the access: pending rvalid is lost, and ram_we drops asynchronously.
- Address/data widths pass through unchanged; no address decoding or range checking.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: L always wins when both unmasked reqs are high (loader-priority for program download while the core is held); the round-robin pointer logic is compiled out.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- k_and_s_pkg gains mem_arb_state_t (ARB_IDLE, ARB_CORE, ARB_LOAD), a port-id enum (PORT_CORE, PORT_LOAD) for the pointer, and MEM_ADDR_W=5 / MEM_DATA_W=16 constants used as parameter defaults.
- One natural sub-module: mem_arb_rr_pick, a 2-way pick with mask and last-served pointer (fixed-priority variant under the macro). The FSM, muxes, and read-return registers stay in mem_arbiter.

Test Plan:
- Reset then idle: no reqs for 5 cycles -> all gnt/ram_we/rvalid 0, busy 0, ram_addr 0.
- Core read: c_req=1, c_we=0, c_addr=5'h03, RAM[3]=16'hBEEF -> c_gnt one cycle after req sampled, ram_addr=3, ram_we=0; next cycle c_rvalid=1, c_rdata=16'hBEEF; l_* outputs idle.
- Loader write then core read of the same word:
  - l_we=1, l_addr=5'h07, l_wdata=16'h1234 -> l_gnt with ram_we=1.
  - Then a core read of addr 7 -> c_rdata=16'h1234.
- Contention, both reqs high continuously, default build -> grants alternate C,L,C,L from the first decision (C first after reset), no idle cycles, and rvalids alternate accordingly. With MEM_ARB_FIXED_PRIO_EN -> L granted, C, L, C (C only on L's masked cycles).
- Lone continuous requester: c_req held high for 6 cycles -> c_gnt pattern 1,0,1,0,1,0.
- Reset mid-operation: assert rst_n=0 in the grant cycle of an L write -> ram_we falls immediately; after release, state ARB_IDLE, no rvalid emitted, core wins the first tie.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared K&S types and constants used by the data-RAM arbiter.
package k_and_s_pkg;

    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CORE = 2'd1,
        ARB_LOAD = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_LOAD = 1'b1
    } port_id_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way requester pick with per-port mask; round-robin by default,
// loader-wins fixed priority when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arb_rr_pick
    import k_and_s_pkg::*;
(
`ifndef MEM_ARB_FIXED_PRIO_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic c_req_i,
    input  logic l_req_i,
    input  logic c_mask_i,
    input  logic l_mask_i,
    output logic c_pick_o,
    output logic l_pick_o
);

    logic c_eff;
    logic l_eff;

    assign c_eff = c_req_i & ~c_mask_i;
    assign l_eff = l_req_i & ~l_mask_i;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign l_pick_o = l_eff;
    assign c_pick_o = c_eff & ~l_eff;
`else
    port_id_t last_q;
    port_id_t last_d;

    // On a tie the port that was not served most recently wins.
    always_comb begin
        c_pick_o = c_eff;
        l_pick_o = l_eff;
        if (c_eff && l_eff) begin
            c_pick_o = (last_q == PORT_LOAD);
            l_pick_o = (last_q == PORT_CORE);
        end
    end

    always_comb begin
        last_d = last_q;
        if (c_pick_o) begin
            last_d = PORT_CORE;
        end else if (l_pick_o) begin
            last_d = PORT_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_LOAD;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data RAM between the core (C) and loader (L) ports.
// Build option: MEM_ARB_FIXED_PRIO_EN selects loader-priority instead of round-robin.
module mem_arbiter
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    mem_arb_state_t    state_q;
    mem_arb_state_t    state_d;
    logic              c_pick;
    logic              l_pick;
    logic              c_rvalid_q;
    logic              l_rvalid_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] l_rdata_q;

    // The port granted this cycle is masked so a lone requester cannot hog the RAM.
    mem_arb_rr_pick u_pick (
`ifndef MEM_ARB_FIXED_PRIO_EN
        .clk      (clk),
        .rst_n    (rst_n),
`endif
        .c_req_i  (c_req),
        .l_req_i  (l_req),
        .c_mask_i (state_q == ARB_CORE),
        .l_mask_i (state_q == ARB_LOAD),
        .c_pick_o (c_pick),
        .l_pick_o (l_pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ARB_IDLE;
        if (c_pick) begin
            state_d = ARB_CORE;
        end else if (l_pick) begin
            state_d = ARB_LOAD;
        end
    end

    always_comb begin
        c_gnt     = 1'b0;
        l_gnt     = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        case (state_q)
            ARB_CORE: begin
                c_gnt     = 1'b1;
                ram_addr  = c_addr;
                ram_wdata = c_wdata;
                ram_we    = c_we;
            end
            ARB_LOAD: begin
                l_gnt     = 1'b1;
                ram_addr  = l_addr;
                ram_wdata = l_wdata;
                ram_we    = l_we;
            end
            default: ;
        endcase
    end

    assign busy = c_gnt | l_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            c_rvalid_q <= c_gnt & ~c_we;
            l_rvalid_q <= l_gnt & ~l_we;
            if (c_rvalid_q) begin
                c_rdata_q <= ram_rdata;
            end
            if (l_rvalid_q) begin
                l_rdata_q <= ram_rdata;
            end
        end
    end

    // RAM data arrives in the rvalid cycle; pass it through then, hold it afterwards.
    assign c_rvalid = c_rvalid_q;
    assign l_rvalid = l_rvalid_q;
    assign c_rdata  = c_rvalid_q ? ram_rdata : c_rdata_q;
    assign l_rdata  = l_rvalid_q ? ram_rdata : l_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
    logic [AW-1:0] c_addr = '0, l_addr = '0;
    logic [DW-1:0] c_wdata = '0, l_wdata = '0;
    logic          c_gnt, c_rvalid, l_gnt, l_rvalid, ram_we, busy;
    logic [DW-1:0] c_rdata, l_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] ram_mem [32];
    logic [DW-1:0] rd_q = '0;

    // Model state: cur/last use 0 = none, 1 = core, 2 = loader.
    int            cur = 0, last = 2, nxt = 0;
    logic          ce, le;
    logic          exp_rv_c = 1'b0, exp_rv_l = 1'b0;
    logic [DW-1:0] exp_rd_c = '0, exp_rd_l = '0;
    logic [DW-1:0] shadow [32];
    logic          c_seen = 1'b0, l_seen = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    // ---------------- clock and RAM model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        rd_q <= ram_mem[ram_addr];
    end
    assign ram_rdata = rd_q;

    // ---------------- behavioural model ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur = 0; last = 2;
            exp_rv_c = 1'b0; exp_rv_l = 1'b0;
            exp_rd_c = '0;   exp_rd_l = '0;
        end else begin
            exp_rv_c = (cur == 1) && !c_we;
            exp_rv_l = (cur == 2) && !l_we;
            if (exp_rv_c) exp_rd_c = shadow[c_addr];
            if (exp_rv_l) exp_rd_l = shadow[l_addr];
            if (cur == 1 && c_we) shadow[c_addr] = c_wdata;
            if (cur == 2 && l_we) shadow[l_addr] = l_wdata;
            ce = c_req && (cur != 1);
            le = l_req && (cur != 2);
            if (ce && le) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                nxt = 2;
`else
                nxt = (last == 1) ? 2 : 1;
`endif
            end else if (ce) nxt = 1;
            else if (le) nxt = 2;
            else nxt = 0;
            if (nxt != 0) last = nxt;
            cur = nxt;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            c_seen = c_gnt;
            l_seen = l_gnt;
            check("c_gnt", c_gnt, cur == 1);
            check("l_gnt", l_gnt, cur == 2);
            check("busy", busy, cur != 0);
            check("ram_we", ram_we, (cur == 1) ? c_we : (cur == 2) ? l_we : 1'b0);
            check("ram_addr", ram_addr, (cur == 1) ? c_addr : (cur == 2) ? l_addr : '0);
            check("ram_wdata", ram_wdata, (cur == 1) ? c_wdata : (cur == 2) ? l_wdata : '0);
            check("c_rvalid", c_rvalid, exp_rv_c);
            check("l_rvalid", l_rvalid, exp_rv_l);
            check("c_rdata", c_rdata, exp_rd_c);
            check("l_rdata", l_rdata, exp_rd_l);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_c();
        c_we    = 1'($urandom_range(0, 1));
        c_addr  = AW'($urandom_range(0, 31));
        c_wdata = DW'($urandom);
    endtask

    task automatic new_l();
        l_we    = 1'($urandom_range(0, 1));
        l_addr  = AW'($urandom_range(0, 31));
        l_wdata = DW'($urandom);
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] pat_c;
    logic [5:0] pat_l;

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram_mem[i] = DW'($urandom);
            shadow[i]  = ram_mem[i];
        end
        ram_mem[3] = 16'hBEEF;
        shadow[3]  = 16'hBEEF;

        repeat (2) tick();
        rst_n = 1'b1;

        // Idle after reset
        repeat (5) begin
            tick();
            check("idle_flags", {c_gnt, l_gnt, ram_we, busy, c_rvalid, l_rvalid}, 6'b0);
            check("idle_addr", ram_addr, 0);
        end

        // Core read of RAM[3]
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h03;
        tick();
        check("rd_gnt", {c_gnt, l_gnt, busy, ram_we}, 4'b1010);
        check("rd_addr", ram_addr, 5'h03);
        c_req = 1'b0;
        tick();
        check("rd_rvalid", {c_rvalid, l_rvalid}, 2'b10);
        check("rd_data", c_rdata, 16'hBEEF);
        tick();
        check("rd_hold", c_rdata, 16'hBEEF);
        check("rd_once", c_rvalid, 0);

        // Loader write then core read of the same word
        l_req = 1'b1; l_we = 1'b1; l_addr = 5'h07; l_wdata = 16'h1234;
        tick();
        check("wr_gnt", {l_gnt, c_gnt, ram_we}, 3'b101);
        check("wr_addr", ram_addr, 5'h07);
        check("wr_data", ram_wdata, 16'h1234);
        l_req = 1'b0;
        tick();
        check("wr_no_rvalid", l_rvalid, 0);
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h07;
        tick();
        check("rb_gnt", c_gnt, 1);
        c_req = 1'b0;
        tick();
        check("rb_data", {15'd0, c_rvalid, c_rdata}, {15'd0, 1'b1, 16'h1234});
        tick();

        // Contention from reset, both requesters always asking
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        pat_c = 6'b101010; pat_l = 6'b010101;
`else
        pat_c = 6'b010101; pat_l = 6'b101010;
`endif
        new_c(); new_l();
        c_req = 1'b1; l_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("cont_c", c_gnt, pat_c[i]);
            check("cont_l", l_gnt, pat_l[i]);
            check("cont_busy", busy, 1);
            if (c_seen) new_c();
            if (l_seen) new_l();
        end
        c_req = 1'b0; l_req = 1'b0;
        repeat (3) tick();

        // Lone continuous requester
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h05;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("lone_c", c_gnt, (i % 2) == 0);
        end
        c_req = 1'b0;
        repeat (3) tick();

        // Reset during a loader write grant
        l_req = 1'b1; l_we = 1'b1; l_addr = 5'h09; l_wdata = 16'hAAAA;
        tick();
        check("mr_pre_we", {l_gnt, ram_we}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_we_drop", {l_gnt, ram_we, busy}, 3'b000);
        l_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_no_rvalid", {c_rvalid, l_rvalid}, 2'b00);
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h09;
        l_req = 1'b1; l_we = 1'b0; l_addr = 5'h0A;
        tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
        check("mr_tie", {c_gnt, l_gnt}, 2'b01);
`else
        check("mr_tie", {c_gnt, l_gnt}, 2'b10);
`endif
        c_req = 1'b0; l_req = 1'b0;
        repeat (3) tick();

        // Random traffic; fields change only after a grant completes
        for (int n = 0; n < 400; n++) begin
            tick();
            if (c_seen) begin
                if ($urandom_range(0, 3) != 0) new_c();
                else c_req = 1'b0;
            end else if (!c_req && $urandom_range(0, 2) == 0) begin
                new_c();
                c_req = 1'b1;
            end
            if (l_seen) begin
                if ($urandom_range(0, 3) != 0) new_l();
                else l_req = 1'b0;
            end else if (!l_req && $urandom_range(0, 2) == 0) begin
                new_l();
                l_req = 1'b1;
            end
        end
        tick();
        c_req = 1'b0; l_req = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
